// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator sequencer: walks a 1-bit equality cell from MSB
// to LSB over two captured operands and reports eq/gt/lt with a start/done handshake.
module serial_cmp_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic                     eq,
    output logic                     gt,
    output logic                     lt,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Sum-of-products 1-bit equality cell, same form as the standalone comparator cell.
    function automatic logic cmp_cell(input logic x, input logic y);
        return (x & y) | (~x & ~y);
    endfunction

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [IW-1:0]     idx_r;
    logic              decided_r;
    logic              gt_acc_r;
    logic              lt_acc_r;

    logic              a_bit_s;
    logic              b_bit_s;
    logic              bit_eq_s;
    logic              first_miss_s;
    logic              finish_s;
    logic              gt_next_s;
    logic              lt_next_s;

    // Bit-under-compare decode and the result that would be latched on a finishing edge.
    always_comb begin
        a_bit_s      = a_r[idx_r];
        b_bit_s      = b_r[idx_r];
        bit_eq_s     = cmp_cell(a_bit_s, b_bit_s);
        first_miss_s = ~bit_eq_s & ~decided_r;
        finish_s     = (idx_r == IW'(0)) | (EARLY_EXIT & ~bit_eq_s);
        if (decided_r) begin
            gt_next_s = gt_acc_r;
            lt_next_s = lt_acc_r;
        end else begin
            gt_next_s = a_bit_s & ~b_bit_s;
            lt_next_s = ~a_bit_s & b_bit_s;
        end
    end

    assign bit_idx = idx_r;

    // Sequencer state, captured operands, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            idx_r     <= '0;
            decided_r <= 1'b0;
            gt_acc_r  <= 1'b0;
            lt_acc_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        a_r       <= a;
                        b_r       <= b;
                        idx_r     <= IW'(WIDTH - 1);
                        decided_r <= 1'b0;
                        gt_acc_r  <= 1'b0;
                        lt_acc_r  <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= S_RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    // abort wins over a finishing edge and leaves eq/gt/lt untouched
                    if (abort) begin
                        idx_r   <= '0;
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (finish_s) begin
                        eq      <= ~(decided_r | ~bit_eq_s);
                        gt      <= gt_next_s;
                        lt      <= lt_next_s;
                        done    <= 1'b1;
                        idx_r   <= '0;
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        idx_r <= idx_r - IW'(1);
                        if (first_miss_s) begin
                            decided_r <= 1'b1;
                            gt_acc_r  <= a_bit_s;
                            lt_acc_r  <= b_bit_s;
                        end else begin
                            decided_r <= decided_r;
                        end
                    end
                end
                default: begin
                    idx_r   <= '0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
